eth_fcs_check_arb_64: RTL and testbench

ETH_FCS_CHECK_ARB_64 -- requirements
Module: eth_fcs_check_arb_64

---
 rtl/eth_fcs_check_arb_64.sv | 174 +++++++++++++++++
 tb/tb_eth_fcs_check_arb_64.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_fcs_check_arb_64.sv
// Two-source frame arbiter in front of a shared FCS checker, with a source-tag FIFO
// that follows frames through the checker. Optional counters: ETH_FCS_ARB_STATS_EN.
module eth_fcs_check_arb_64 #(
  parameter int unsigned TAG_DEPTH = 4,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [63:0]          s0_axis_tdata,
  input  logic [7:0]           s0_axis_tkeep,
  input  logic                 s0_axis_tvalid,
  input  logic                 s0_axis_tlast,
  input  logic                 s0_axis_tuser,
  output logic                 s0_axis_tready,
  input  logic [63:0]          s1_axis_tdata,
  input  logic [7:0]           s1_axis_tkeep,
  input  logic                 s1_axis_tvalid,
  input  logic                 s1_axis_tlast,
  input  logic                 s1_axis_tuser,
  output logic                 s1_axis_tready,
  output logic [63:0]          m_axis_tdata,
  output logic [7:0]           m_axis_tkeep,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  input  logic                 m_axis_tready,
  input  logic                 chk_frame_done,
  input  logic                 chk_bad_fcs,
  output logic                 done_src,
  output logic                 done_src_valid,
  output logic                 busy,
  output logic                 grant_src,
  output logic                 tag_underflow
`ifdef ETH_FCS_ARB_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] stat_ok0,
  output logic [CNT_WIDTH-1:0] stat_ok1,
  output logic [CNT_WIDTH-1:0] stat_bad0,
  output logic [CNT_WIDTH-1:0] stat_bad1
`endif
);

  localparam int unsigned PtrW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;

  logic [1:0]           state_q, state_d;
  logic                 last_q, last_d;
  logic [TAG_DEPTH-1:0] tag_mem_q;
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q;
  logic                 underflow_q;

  logic fifo_full, fifo_empty, push, pop, accept_last, pick;

  assign fifo_full   = (count_q == CntW'(TAG_DEPTH));
  assign fifo_empty  = (count_q == '0);
  assign accept_last = m_axis_tvalid & m_axis_tready & m_axis_tlast;
  assign push        = accept_last;
  assign pop         = chk_frame_done & ~fifo_empty;

  assign busy           = (state_q != IDLE);
  assign grant_src      = (state_q == GNT1);
  assign done_src_valid = ~fifo_empty;
  assign done_src       = ~fifo_empty & tag_mem_q[rd_ptr_q];
  assign tag_underflow  = underflow_q;

  // Pure combinational mux: the granted source sees the checker's tready directly.
  always_comb begin
    m_axis_tdata   = '0;
    m_axis_tkeep   = '0;
    m_axis_tvalid  = 1'b0;
    m_axis_tlast   = 1'b0;
    m_axis_tuser   = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    case (state_q)
      GNT0: begin
        m_axis_tdata   = s0_axis_tdata;
        m_axis_tkeep   = s0_axis_tkeep;
        m_axis_tvalid  = s0_axis_tvalid;
        m_axis_tlast   = s0_axis_tlast;
        m_axis_tuser   = s0_axis_tuser;
        s0_axis_tready = m_axis_tready;
      end
      GNT1: begin
        m_axis_tdata   = s1_axis_tdata;
        m_axis_tkeep   = s1_axis_tkeep;
        m_axis_tvalid  = s1_axis_tvalid;
        m_axis_tlast   = s1_axis_tlast;
        m_axis_tuser   = s1_axis_tuser;
        s1_axis_tready = m_axis_tready;
      end
      default: ;
    endcase
  end

  // On contention the source not granted last wins; with one requester it simply wins.
  assign pick = (s0_axis_tvalid & s1_axis_tvalid) ? ~last_q : s1_axis_tvalid;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (!fifo_full && (s0_axis_tvalid || s1_axis_tvalid)) begin
          state_d = pick ? GNT1 : GNT0;
          last_d  = pick;
        end
      end
      GNT0, GNT1: begin
        if (accept_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_mem_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      if (push) begin
        tag_mem_q[wr_ptr_q] <= grant_src;
        wr_ptr_q            <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: ;
      endcase
      if (chk_frame_done && fifo_empty) underflow_q <= 1'b1;
    end
  end

`ifdef ETH_FCS_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ok0  <= '0;
      stat_ok1  <= '0;
      stat_bad0 <= '0;
      stat_bad1 <= '0;
    end else if (pop) begin
      case ({chk_bad_fcs, done_src})
        2'b00:   if (stat_ok0 != '1) stat_ok0 <= stat_ok0 + CNT_WIDTH'(1);
        2'b01:   if (stat_ok1 != '1) stat_ok1 <= stat_ok1 + CNT_WIDTH'(1);
        2'b10:   if (stat_bad0 != '1) stat_bad0 <= stat_bad0 + CNT_WIDTH'(1);
        default: if (stat_bad1 != '1) stat_bad1 <= stat_bad1 + CNT_WIDTH'(1);
      endcase
    end
  end
`else
  logic unused_bad_fcs;
  assign unused_bad_fcs = chk_bad_fcs;
`endif

endmodule

// File: tb/tb_eth_fcs_check_arb_64.sv
// Self-checking bench for eth_fcs_check_arb_64: beat/tag scoreboards plus directed corners.
`timescale 1ns/1ps
module tb_eth_fcs_check_arb_64;

  localparam int CNT_WIDTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] s_tdata [2];
  logic [7:0]  s_tkeep [2];
  logic        s_tvalid[2];
  logic        s_tlast [2];
  logic        s_tuser [2];
  logic        s_tready[2];
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic        m_axis_tready;
  logic        chk_frame_done, chk_bad_fcs;
  logic        done_src, done_src_valid, busy, grant_src, tag_underflow;
`ifdef ETH_FCS_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] stat_ok0, stat_ok1, stat_bad0, stat_bad1;
`endif

  eth_fcs_check_arb_64 #(.TAG_DEPTH(4), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s0_axis_tdata  (s_tdata[0]),
    .s0_axis_tkeep  (s_tkeep[0]),
    .s0_axis_tvalid (s_tvalid[0]),
    .s0_axis_tlast  (s_tlast[0]),
    .s0_axis_tuser  (s_tuser[0]),
    .s0_axis_tready (s_tready[0]),
    .s1_axis_tdata  (s_tdata[1]),
    .s1_axis_tkeep  (s_tkeep[1]),
    .s1_axis_tvalid (s_tvalid[1]),
    .s1_axis_tlast  (s_tlast[1]),
    .s1_axis_tuser  (s_tuser[1]),
    .s1_axis_tready (s_tready[1]),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tuser   (m_axis_tuser),
    .m_axis_tready  (m_axis_tready),
    .chk_frame_done (chk_frame_done),
    .chk_bad_fcs    (chk_bad_fcs),
    .done_src       (done_src),
    .done_src_valid (done_src_valid),
    .busy           (busy),
    .grant_src      (grant_src),
    .tag_underflow  (tag_underflow)
`ifdef ETH_FCS_ARB_STATS_EN
    ,
    .stat_ok0       (stat_ok0),
    .stat_ok1       (stat_ok1),
    .stat_bad0      (stat_bad0),
    .stat_bad1      (stat_bad1)
`endif
  );

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
    logic        gap;
  } beat_t;

  typedef struct packed {
    logic        src;
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } exp_t;

  typedef struct {
    logic        s0v, s1v, mrdy, lst, usr;
    logic [63:0] d0, d1;
    logic [8:0]  exp_ctrl;
    logic [63:0] exp_data;
  } rst_vec_t;

  beat_t srcq[2][$];
  exp_t  exp_q[$];
  logic  tag_q[$];
  logic  chk_q[$];
  bit    drv_en = 0;
  bit    auto_drain = 0;
  int    beats_seen = 0;
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input int src, input int fid, input int nbeats, input int gap_at,
                      input bit push_tag);
    beat_t b;
    exp_t  e;
    for (int i = 0; i < nbeats; i++) begin
      b.data = {8'(src), 24'(fid), 32'(i)};
      b.keep = (i == nbeats - 1) ? 8'h0F : 8'hFF;
      b.last = (i == nbeats - 1);
      b.user = (i == nbeats - 1) ? 1'(fid) : 1'b0;
      b.gap  = (i == gap_at);
      srcq[src].push_back(b);
      e.src = 1'(src); e.data = b.data; e.keep = b.keep; e.last = b.last; e.user = b.user;
      exp_q.push_back(e);
    end
    if (push_tag) tag_q.push_back(1'(src));
  endtask

  task automatic pulse(input logic bad);
    chk_q.push_back(bad);
  endtask

  // Background: scoreboard monitor on the falling edge, source drivers after the rising edge.
  task automatic bg_loop();
    logic  fire[2];
    bit    gapped[2];
    bit    idle_chk;
    logic  dv_s, chk_prev, t;
    exp_t  e;
    beat_t b;
    gapped[0] = 0; gapped[1] = 0; idle_chk = 0;
    forever begin
      @(negedge clk);
      if (idle_chk) begin
        check("idle_between_frames", {79'b0, busy}, 80'd0);
        idle_chk = 0;
      end
      if (rst_n && m_axis_tvalid && m_axis_tready) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 80'd1, 80'd0);
        end else begin
          e = exp_q.pop_front();
          check("beat", {5'b0, grant_src, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser},
                {5'b0, e});
        end
        if (m_axis_tlast) idle_chk = 1;
      end
      if (rst_n && chk_frame_done) begin
        if (tag_q.size() > 0) begin
          t = tag_q.pop_front();
          check("tag_pop", {78'b0, done_src_valid, done_src}, {78'b0, 1'b1, t});
        end else begin
          check("tag_empty_valid", {79'b0, done_src_valid}, 80'd0);
        end
      end
      for (int s = 0; s < 2; s++) fire[s] = s_tvalid[s] && s_tready[s];
      dv_s     = done_src_valid;
      chk_prev = chk_frame_done;
      @(posedge clk);
      #1;
      chk_frame_done = 1'b0;
      chk_bad_fcs    = 1'b0;
      if (chk_q.size() > 0) begin
        chk_frame_done = 1'b1;
        chk_bad_fcs    = chk_q.pop_front();
      end else if (auto_drain && dv_s && !chk_prev) begin
        chk_frame_done = 1'b1;
      end
      if (drv_en) begin
        for (int s = 0; s < 2; s++) begin
          if (fire[s] && srcq[s].size() > 0) begin
            b = srcq[s].pop_front();
            gapped[s] = 0;
          end
          if (srcq[s].size() > 0) begin
            b = srcq[s][0];
            s_tdata[s] = b.data; s_tkeep[s] = b.keep;
            s_tlast[s] = b.last; s_tuser[s] = b.user;
            if (b.gap && !gapped[s]) begin
              s_tvalid[s] = 1'b0;
              gapped[s]   = 1;
            end else begin
              s_tvalid[s] = 1'b1;
            end
          end else begin
            s_tvalid[s] = 1'b0; s_tdata[s] = '0; s_tkeep[s] = '0;
            s_tlast[s]  = 1'b0; s_tuser[s] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() > 0 || srcq[0].size() > 0 || srcq[1].size() > 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, 80'(n < 2000), 80'd1);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    srcq[0].delete(); srcq[1].delete();
    exp_q.delete(); tag_q.delete(); chk_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_vec_t rv[4];
    int n, base;

    for (int s = 0; s < 2; s++) begin
      s_tdata[s] = '0; s_tkeep[s] = '0; s_tvalid[s] = 1'b0; s_tlast[s] = 1'b0; s_tuser[s] = 1'b0;
    end
    m_axis_tready  = 1'b1;
    chk_frame_done = 1'b0;
    chk_bad_fcs    = 1'b0;
    fork
      bg_loop();
    join_none

    // In reset every control output is 0 and data is 0 since IDLE selects nothing.
    rv[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 9'h0, 64'h0};
    rv[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 64'hDEAD_BEEF_0000_0001, 64'h0, 9'h0, 64'h0};
    rv[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 64'h1234_5678_9ABC_DEF0, 9'h0, 64'h0};
    rv[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h5555, 9'h0, 64'h0};
    #12;
    for (int i = 0; i < 4; i++) begin
      s_tvalid[0] = rv[i].s0v; s_tvalid[1] = rv[i].s1v; m_axis_tready = rv[i].mrdy;
      s_tdata[0] = rv[i].d0; s_tdata[1] = rv[i].d1; s_tkeep[0] = 8'hFF; s_tkeep[1] = 8'hFF;
      s_tlast[0] = rv[i].lst; s_tlast[1] = rv[i].lst; s_tuser[0] = rv[i].usr; s_tuser[1] = rv[i].usr;
      #7;
      check("rst_ctrl", {71'b0, m_axis_tvalid, s_tready[0], s_tready[1], busy, grant_src,
                         done_src_valid, tag_underflow, m_axis_tlast, m_axis_tuser},
            {71'b0, rv[i].exp_ctrl});
      check("rst_data", {16'b0, m_axis_tdata}, {16'b0, rv[i].exp_data});
    end
    for (int s = 0; s < 2; s++) begin
      s_tvalid[s] = 1'b0; s_tdata[s] = '0; s_tlast[s] = 1'b0; s_tuser[s] = 1'b0;
    end
    drv_en = 1;
    @(negedge clk);
    rst_n = 1'b1;

    // Single 3-beat frame from s0, with one cycle of checker backpressure at grant.
    m_axis_tready = 1'b0;
    @(negedge clk);
    send(0, 1, 3, -1, 1);
    n = 0;
    while (!s_tvalid[0] && n < 50) begin @(negedge clk); n++; end
    check("t1_idle_busy", {79'b0, busy}, 80'd0);
    check("t1_idle_ready", {78'b0, s_tready[0], m_axis_tvalid}, 80'd0);
    @(negedge clk);
    check("t1_gnt0", {75'b0, busy, grant_src, s_tready[0], s_tready[1], m_axis_tvalid},
          {75'b0, 5'b10001});
    @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    @(negedge clk);
    check("t1_ready_follow", {78'b0, s_tready[0], s_tready[1]}, {78'b0, 2'b10});
    wait_idle("t1");
    check("t1_tag", {78'b0, done_src_valid, done_src}, {78'b0, 2'b10});
    pulse(0);
    repeat (3) @(negedge clk);
    check("t1_drained", {79'b0, done_src_valid}, 80'd0);

    // Round-robin from reset: both sources backlogged, order 0,1,0,1...
    do_reset();
    auto_drain = 1;
    for (int k = 0; k < 4; k++) begin
      send(0, 20 + k, 2, -1, 1);
      send(1, 30 + k, 2, -1, 1);
    end
    wait_idle("rr");
    auto_drain = 0;
    repeat (6) @(negedge clk);
    check("rr_drained", {78'b0, done_src_valid, tag_underflow}, 80'd0);

    // Tag FIFO full: the fifth frame waits; one pop grants it two cycles later.
    for (int k = 0; k < 5; k++) send(0, 40 + k, 2, -1, 1);
    n = 0;
    while (exp_q.size() > 2 && n < 200) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    check("full_stall", {76'b0, busy, s_tvalid[0], m_axis_tvalid, done_src_valid},
          {76'b0, 4'b0101});
    check("full_pending", 80'(exp_q.size()), 80'd2);
    pulse(0);
    n = 0;
    while (!chk_frame_done && n < 10) begin @(negedge clk); n++; end
    check("full_pop_cycle", {79'b0, busy}, 80'd0);
    @(negedge clk);
    check("full_next_cycle", {79'b0, busy}, 80'd0);
    @(negedge clk);
    check("full_grant", {78'b0, busy, grant_src}, {78'b0, 2'b10});
    wait_idle("full");
    repeat (4) pulse(0);
    repeat (8) @(negedge clk);
    check("full_drained", {78'b0, done_src_valid, tag_underflow}, 80'd0);

    // A tvalid gap mid-frame on s1 must not let s0 take the grant.
    send(1, 11, 3, 1, 1);
    send(0, 12, 2, -1, 1);
    wait_idle("gap");
    repeat (2) pulse(0);
    repeat (5) @(negedge clk);

    // Underflow: done with an empty FIFO is sticky and leaves the count at zero.
    pulse(0);
    repeat (3) @(negedge clk);
    check("uf_sticky", {78'b0, tag_underflow, done_src_valid}, {78'b0, 2'b10});
    send(1, 51, 1, -1, 1);
    wait_idle("uf");
    check("uf_count0", {78'b0, done_src_valid, done_src}, {78'b0, 2'b11});
    pulse(0);
    repeat (3) @(negedge clk);
    check("uf_still", {78'b0, tag_underflow, done_src_valid}, {78'b0, 2'b10});
    do_reset();
    check("uf_cleared", {78'b0, tag_underflow, done_src_valid}, 80'd0);

    // Reset on beat 2 of a 4-beat frame abandons it; arbitration afterwards is normal.
    @(negedge clk);
    base = beats_seen;
    send(1, 60, 4, -1, 0);
    n = 0;
    while (beats_seen - base < 2 && n < 50) begin @(negedge clk); #1; n++; end
    rst_n = 1'b0;
    srcq[0].delete(); srcq[1].delete(); exp_q.delete(); tag_q.delete();
    #1;
    check("midrst_state", {76'b0, busy, s_tready[1], m_axis_tvalid, done_src_valid}, 80'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(0, 61, 1, -1, 1);
    send(1, 62, 1, -1, 1);
    wait_idle("midrst");
    check("midrst_tag", {78'b0, done_src_valid, done_src}, {78'b0, 2'b10});
    repeat (2) pulse(0);
    repeat (4) @(negedge clk);

`ifdef ETH_FCS_ARB_STATS_EN
    do_reset();
    send(1, 70, 2, -1, 1);
    wait_idle("st1");
    send(0, 71, 2, -1, 1);
    wait_idle("st0");
    pulse(1);
    pulse(0);
    repeat (4) @(negedge clk);
    check("stat_bad1", 80'(stat_bad1), 80'd1);
    check("stat_ok0", 80'(stat_ok0), 80'd1);
    check("stat_others", 80'(stat_ok1) | 80'(stat_bad0), 80'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
